// File: rtl/rl_pkg.sv
// Shared widths, saturation bounds and FSM encoding for the Q-learning update engine.
package rl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned ACT_W   = 2;
    localparam int unsigned Q_W     = 16;
    localparam int unsigned ADDR_W  = 6;

    localparam logic signed [Q_W-1:0] Q_MAX = {1'b0, {(Q_W-1){1'b1}}};
    localparam logic signed [Q_W-1:0] Q_MIN = {1'b1, {(Q_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        RD_NEXT,
        RD_CUR,
        CALC,
        WRITE
    } fsm_state_e;

endpackage

// File: rtl/q_bellman_alu.sv
// Combinational Bellman update: new_q = q + ((r + gamma*max_q - q) >>> alpha_shift).
// Define Q_SAT_EN to saturate the result to the Q range instead of wrapping.
module q_bellman_alu #(
    parameter int unsigned Q_W = rl_pkg::Q_W
) (
    input  logic signed [Q_W-1:0] q_cur,
    input  logic signed [Q_W-1:0] max_q,
    input  logic signed [Q_W-1:0] reward,
    input  logic        [3:0]     alpha_shift,
    input  logic        [3:0]     gamma_shift,
    output logic signed [Q_W-1:0] new_q
);
    import rl_pkg::*;

    localparam int unsigned EXT_W = Q_W + 3;

    logic signed [EXT_W-1:0] q_x, m_x, r_x, g, target, delta, sum;

    always_comb begin
        q_x    = {{3{q_cur[Q_W-1]}}, q_cur};
        m_x    = {{3{max_q[Q_W-1]}}, max_q};
        r_x    = {{3{reward[Q_W-1]}}, reward};
        // gamma = 1 - 2^-gamma_shift, so gamma_shift = 0 yields g = 0
        g      = m_x - (m_x >>> gamma_shift);
        target = r_x + g;
        delta  = target - q_x;
        sum    = q_x + (delta >>> alpha_shift);
    end

`ifdef Q_SAT_EN
    logic [EXT_W-Q_W:0] sum_hi;

    always_comb begin
        sum_hi = sum[EXT_W-1:Q_W-1];
        if ((&sum_hi) || !(|sum_hi)) begin
            new_q = sum[Q_W-1:0];
        end else begin
            new_q = sum[EXT_W-1] ? Q_MIN : Q_MAX;
        end
    end
`else
    logic unused_sum_hi;

    assign unused_sum_hi = ^sum[EXT_W-1:Q_W];
    assign new_q         = sum[Q_W-1:0];
`endif

endmodule

// File: rtl/q_update_engine.sv
// Tabular Q-learning update stage driving a 64-entry action RAM with 1-cycle read latency.
// Define Q_SAT_EN to saturate the updated Q-value instead of two's-complement wrapping.
module q_update_engine #(
    parameter int unsigned STATE_W = rl_pkg::STATE_W,
    parameter int unsigned ACT_W   = rl_pkg::ACT_W,
    parameter int unsigned Q_W     = rl_pkg::Q_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [STATE_W-1:0]        cur_state,
    input  logic [ACT_W-1:0]          cur_action,
    input  logic [STATE_W-1:0]        next_state,
    input  logic [Q_W-1:0]            reward,
    input  logic [3:0]                alpha_shift,
    input  logic [3:0]                gamma_shift,
    output logic                      busy,
    output logic                      done,
    output logic [ACT_W-1:0]          best_action,
    output logic                      ram_en,
    output logic [rl_pkg::ADDR_W-1:0] ram_rd_addr,
    output logic [rl_pkg::ADDR_W-1:0] ram_wr_addr,
    output logic                      ram_write_en,
    output logic [Q_W-1:0]            ram_data_in,
    input  logic [Q_W-1:0]            ram_data_out
);
    import rl_pkg::*;

    fsm_state_e state_q, state_d;

    logic [STATE_W-1:0]    s_q, sn_q;
    logic [ACT_W-1:0]      a_q, cnt_q, best_idx_q, best_action_q, trk_idx;
    logic signed [Q_W-1:0] reward_q, max_q, new_q_q, alu_new_q;
    logic [3:0]            alpha_q, gamma_q;
    logic                  trk_en, trk_first;

    // Read data lags the issued address by one cycle, so RD_CUR sees the last s' action
    always_comb begin
        trk_en    = (state_q == RD_NEXT && cnt_q != '0) || (state_q == RD_CUR);
        trk_idx   = (state_q == RD_CUR) ? '1 : cnt_q - ACT_W'(1);
        trk_first = (trk_idx == '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RD_NEXT;
            RD_NEXT: if (&cnt_q) state_d = RD_CUR;
            RD_CUR:  state_d = CALC;
            CALC:    state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            s_q           <= '0;
            sn_q          <= '0;
            a_q           <= '0;
            cnt_q         <= '0;
            reward_q      <= '0;
            alpha_q       <= '0;
            gamma_q       <= '0;
            max_q         <= '0;
            best_idx_q    <= '0;
            new_q_q       <= '0;
            best_action_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                s_q      <= cur_state;
                a_q      <= cur_action;
                sn_q     <= next_state;
                reward_q <= reward;
                alpha_q  <= alpha_shift;
                gamma_q  <= gamma_shift;
                cnt_q    <= '0;
            end
            if (state_q == RD_NEXT) begin
                cnt_q <= cnt_q + ACT_W'(1);
            end
            // Strict compare keeps the lowest action index on ties
            if (trk_en && (trk_first || $signed(ram_data_out) > max_q)) begin
                max_q      <= ram_data_out;
                best_idx_q <= trk_idx;
            end
            if (state_q == CALC) begin
                new_q_q       <= alu_new_q;
                best_action_q <= best_idx_q;
            end
        end
    end

    // ram_data_out holds Q(s,a) throughout CALC
    q_bellman_alu #(
        .Q_W(Q_W)
    ) u_alu (
        .q_cur      (ram_data_out),
        .max_q      (max_q),
        .reward     (reward_q),
        .alpha_shift(alpha_q),
        .gamma_shift(gamma_q),
        .new_q      (alu_new_q)
    );

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        ram_en       = 1'b0;
        ram_rd_addr  = '0;
        ram_wr_addr  = '0;
        ram_write_en = 1'b0;
        ram_data_in  = '0;
        unique case (state_q)
            IDLE: ;
            RD_NEXT: begin
                busy        = 1'b1;
                ram_en      = 1'b1;
                ram_rd_addr = {sn_q, cnt_q};
            end
            RD_CUR, CALC: begin
                busy        = 1'b1;
                ram_en      = 1'b1;
                ram_rd_addr = {s_q, a_q};
            end
            WRITE: begin
                busy         = 1'b1;
                done         = 1'b1;
                ram_en       = 1'b1;
                ram_write_en = 1'b1;
                ram_wr_addr  = {s_q, a_q};
                ram_data_in  = new_q_q;
            end
            default: ;
        endcase
    end

    assign best_action = best_action_q;

endmodule

// File: tb/tb_q_update_engine.sv
// Directed self-checking bench for q_update_engine with a behavioural 64x16 action RAM.
module tb_q_update_engine;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  cur_state, next_state;
    logic [1:0]  cur_action;
    logic [15:0] reward;
    logic [3:0]  alpha_shift, gamma_shift;
    logic        busy, done, ram_en, ram_write_en;
    logic [1:0]  best_action;
    logic [5:0]  ram_rd_addr, ram_wr_addr;
    logic [15:0] ram_data_in, ram_data_out;

    logic [15:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_addr;
    logic [15:0] pl_data;
    int          wr_count;
    int          done_count;
    int          checks;
    int          errors;
    int          cyc;
    int          wr_base;
    int          done_base;
    logic [15:0] ovf_exp;

    always #5 clk = ~clk;

    q_update_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cur_state   (cur_state),
        .cur_action  (cur_action),
        .next_state  (next_state),
        .reward      (reward),
        .alpha_shift (alpha_shift),
        .gamma_shift (gamma_shift),
        .busy        (busy),
        .done        (done),
        .best_action (best_action),
        .ram_en      (ram_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_wr_addr (ram_wr_addr),
        .ram_write_en(ram_write_en),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    // Action RAM: write has priority over read, read data appears one cycle later
    always @(posedge clk) begin
        if (done) done_count <= done_count + 1;
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            if (ram_write_en) begin
                mem[ram_wr_addr] <= ram_data_in;
                wr_count         <= wr_count + 1;
            end else begin
                ram_data_out <= mem[ram_rd_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] addr, input logic [15:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Returns at the negedge of cycle 1; inputs are then scrambled to prove latching
    task automatic launch(input logic [3:0] s, input logic [1:0] a, input logic [3:0] sn,
                          input logic [15:0] r, input logic [3:0] as, input logic [3:0] gs);
        @(negedge clk);
        cur_state   = s;
        cur_action  = a;
        next_state  = sn;
        reward      = r;
        alpha_shift = as;
        gamma_shift = gs;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        cur_state   = ~s;
        cur_action  = ~a;
        next_state  = ~sn;
        reward      = ~r;
        alpha_shift = ~as;
        gamma_shift = ~gs;
    endtask

    task automatic wait_done(input int from_cycle, output int done_cyc);
        done_cyc = -1;
        for (int c = from_cycle; c < from_cycle + 20; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        start       = 1'b0;
        cur_state   = '0;
        cur_action  = '0;
        next_state  = '0;
        reward      = '0;
        alpha_shift = '0;
        gamma_shift = '0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
`ifdef Q_SAT_EN
        ovf_exp = 16'h7FFF;
`else
        ovf_exp = 16'hDF3F;
`endif

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_write_en", ram_write_en, 0);
        check("rst_rd_addr", ram_rd_addr, 0);
        check("rst_wr_addr", ram_wr_addr, 0);
        check("rst_data_in", ram_data_in, 0);
        check("rst_best_action", best_action, 0);
        rst = 1'b0;

        // Basic update: s=2 a=1 s'=3, tie between actions 1 and 3
        preload(6'd12, 16'h0100);
        preload(6'd13, 16'h0400);
        preload(6'd14, 16'h0200);
        preload(6'd15, 16'h0400);
        preload(6'd9, 16'h0200);
        wr_base = wr_count;
        launch(4'd2, 2'd1, 4'd3, 16'h0100, 4'd1, 4'd2);
        check("basic_busy_c1", busy, 1);
        check("basic_rd_addr_c1", ram_rd_addr, 12);
        wait_done(1, cyc);
        check("basic_done_cycle", cyc, 7);
        check("basic_write_en", ram_write_en, 1);
        check("basic_wr_addr", ram_wr_addr, 9);
        check("basic_data_in", ram_data_in, 16'h0300);
        check("basic_best_action", best_action, 1);
        @(negedge clk);
        check("basic_busy_after", busy, 0);
        check("basic_mem9", mem[9], 16'h0300);
        check("basic_write_count", wr_count - wr_base, 1);
        check("basic_best_hold", best_action, 1);

        // All-negative s' row: max -0.5 at action 2; g=-0.25, target=0.75
        preload(6'd20, 16'hFF00);
        preload(6'd21, 16'hFE00);
        preload(6'd22, 16'hFF80);
        preload(6'd23, 16'hFC00);
        preload(6'd0, 16'h0000);
        launch(4'd0, 2'd0, 4'd5, 16'h0100, 4'd0, 4'd1);
        wait_done(1, cyc);
        check("neg_done_cycle", cyc, 7);
        check("neg_best_action", best_action, 2);
        check("neg_data_in", ram_data_in, 16'h00C0);

        // Overflow: target exceeds the Q range
        preload(6'd27, 16'h7F00);
        for (int i = 28; i < 32; i++) preload(6'(i), 16'h7F00);
        launch(4'd6, 2'd3, 4'd7, 16'h7FFF, 4'd0, 4'd2);
        wait_done(1, cyc);
        check("ovf_done_cycle", cyc, 7);
        check("ovf_data_in", ram_data_in, ovf_exp);
        check("ovf_best_action", best_action, 0);
        @(negedge clk);
        check("ovf_mem27", mem[27], ovf_exp);

        // start pulses at cycles 2 and 7 must be ignored
        preload(6'd6, 16'h0000);
        for (int i = 32; i < 36; i++) preload(6'(i), 16'h0000);
        wr_base   = wr_count;
        done_base = done_count;
        launch(4'd1, 2'd2, 4'd8, 16'h0080, 4'd1, 4'd3);
        @(negedge clk);
        start       = 1'b1;
        cur_state   = 4'd0;
        cur_action  = 2'd0;
        next_state  = 4'd3;
        reward      = 16'h1000;
        alpha_shift = 4'd0;
        gamma_shift = 4'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, cyc);
        check("ign_done_cycle", cyc, 7);
        check("ign_data_in", ram_data_in, 16'h0040);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy_c8", busy, 0);
        repeat (10) @(negedge clk);
        check("ign_done_count", done_count - done_base, 1);
        check("ign_write_count", wr_count - wr_base, 1);
        check("ign_mem6", mem[6], 16'h0040);
        check("ign_mem0", mem[0], 16'h00C0);

        // rst in CALC drops the pending write
        preload(6'd37, 16'h1234);
        for (int i = 40; i < 44; i++) preload(6'(i), 16'h0000);
        wr_base = wr_count;
        launch(4'd9, 2'd1, 4'd10, 16'h0500, 4'd0, 4'd0);
        repeat (5) @(negedge clk);
        check("rst_calc_busy", busy, 1);
        check("rst_calc_write_en", ram_write_en, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_write_en", ram_write_en, 0);
        check("rst_mid_done", done, 0);
        repeat (5) @(negedge clk);
        check("rst_mid_mem37", mem[37], 16'h1234);
        check("rst_mid_write_count", wr_count - wr_base, 0);

        // gamma_shift=0, alpha_shift=0: new Q equals reward
        preload(6'd46, 16'h3456);
        preload(6'd48, 16'h7000);
        preload(6'd49, 16'h1000);
        preload(6'd50, 16'h2000);
        preload(6'd51, 16'h0100);
        launch(4'd11, 2'd2, 4'd12, 16'hFE00, 4'd0, 4'd0);
        wait_done(1, cyc);
        check("g0a0_done_cycle", cyc, 7);
        check("g0a0_data_in", ram_data_in, 16'hFE00);
        check("g0a0_best_action", best_action, 0);
        @(negedge clk);
        check("g0a0_mem46", mem[46], 16'hFE00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/q_update_engine.md
Name: q_update_engine

Overview:
- Tabular Q-learning update stage that sits directly upstream of the 64x16 action RAM and drives its rd_addr, wr_addr, write_en, en and data_in ports.
- One update step runs per start pulse: read Q(s',*), find the max, read Q(s,a), compute the Bellman update, write the new Q(s,a).
- RAM address is {state, action}. RAM read latency is 1 cycle. When the RAM sees write_en, the write takes priority over the read.

Parameters:
- STATE_W, 4, state index width.
- ACT_W, 2, action index width; N_ACT = 2**ACT_W. Must satisfy STATE_W+ACT_W == 6.
- Q_W, 16, Q-value width, signed Q8.8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one update; sampled only in IDLE.
- cur_state  in  STATE_W  s.
- cur_action  in  ACT_W  a.
- next_state  in  STATE_W  s'.
- reward  in  Q_W  signed Q8.8 r.
- alpha_shift  in  4  alpha = 2^-alpha_shift.
- gamma_shift  in  4  gamma = 1 - 2^-gamma_shift.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse in the WRITE cycle.
- best_action  out  ACT_W  greedy action of s'; valid from done until the next done.
- ram_en  out  1  to RAM en.
- ram_rd_addr  out  6  to RAM rd_addr.
- ram_wr_addr  out  6  to RAM wr_addr.
- ram_write_en  out  1  to RAM write_en.
- ram_data_in  out  Q_W  to RAM data_in.
- ram_data_out  in  Q_W  from RAM data_out.

Behaviour:
- Reset values: state IDLE; busy, done, ram_en and ram_write_en = 0; ram addresses, ram_data_in and best_action = 0.
- Input latching: at start in IDLE, all inputs are latched. Later input changes have no effect.
- FSM: IDLE -> RD_NEXT (N_ACT cycles) -> RD_CUR (1) -> CALC (1) -> WRITE (1) -> IDLE.
  - Cycle 0 is the start-accept cycle.
  - RD_NEXT cycle k (k = 0..N_ACT-1): ram_rd_addr = {s', k}.
  - RD_CUR: ram_rd_addr = {s, a}.
  - The RAM value for each address issued returns one cycle later.
- Max tracking:
  - The first returned value loads max_q directly.
  - Each later value replaces max_q only if strictly greater (signed compare), so ties go to the lowest action index.
  - best_idx tracks the winning action.
- Control outputs:
  - ram_en = 1 in every non-IDLE state.
  - ram_write_en = 1 only in WRITE, with ram_wr_addr = {s, a} and ram_data_in = new_q.
- CALC arithmetic (19-bit signed, all shifts arithmetic):
  - g = max_q - (max_q >>> gamma_shift)
  - target = reward + g
  - delta = target - q_cur
  - new_q = q_cur + (delta >>> alpha_shift), then reduced to Q_W (see Optional Feature).
  - new_q is registered at the end of CALC.
- Latency: done asserts in cycle N_ACT+3 (cycle 7 by default). best_action updates in the same cycle. busy drops the following cycle.
- start while busy is ignored; there is no queueing.
- start in the same cycle as done (WRITE) is ignored; accept only in IDLE.
- gamma_shift = 0 gives g = 0. alpha_shift = 0 gives new_q = target.
- rst mid-operation: return to IDLE next cycle, ram_write_en = 0. The pending write is dropped and the RAM is left unmodified.

Optional Feature:
- Macro Q_SAT_EN.
- Defined: new_q saturates to [-2^(Q_W-1), 2^(Q_W-1)-1].
- Undefined: new_q is the low Q_W bits (two's-complement wrap).

Decomposition:
- Package rl_pkg holds:
  - Q_W, STATE_W, ACT_W, ADDR_W = 6
  - FSM state enum {IDLE, RD_NEXT, RD_CUR, CALC, WRITE}
  - Q_MAX and Q_MIN constants
- One natural combinational sub-module, q_bellman_alu: maps (q_cur, max_q, reward, shifts) to new_q, and contains the Q_SAT_EN saturation.

Test Plan:
- Basic update, alpha_shift=1, gamma_shift=2, s=2, a=1, s'=3, r=0x0100.
  - Preload mem[12..15] = 0x0100, 0x0400, 0x0200, 0x0400 and mem[9] = 0x0200.
  - Expect: write mem[9] = 0x0300; done at cycle 7; best_action = 1 (tie resolves to lowest index).
- All-negative s' row: mem[12..15] = 0xFF00, 0xFE00, 0xFF80, 0xFC00 -> max_q = 0xFF80, best_action = 2.
- Overflow case, alpha_shift=0, gamma_shift=2, Q(s,a)=0x7F00, all Q(s',*)=0x7F00, r=0x7FFF:
  - with Q_SAT_EN, write 0x7FFF;
  - without Q_SAT_EN, write 0xDF3F.
- start pulses at cycles 2 and 7 of a running update -> both ignored; exactly one write and one done.
- rst asserted in CALC -> no ram_write_en, busy = 0 the next cycle, RAM contents unchanged.
- gamma_shift=0, alpha_shift=0, r=0xFE00 -> new Q(s,a) = 0xFE00 regardless of table contents.
